// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction memory: a 16-bit little-endian word count,
// then that many little-endian 32-bit words. The core is held in reset while a load runs.
module imem_loader #(
   parameter int DEPTH    = 128,
   parameter bit AUTO_RUN = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        WE,
   output logic [31:0] WA,
   output logic [31:0] WD,
   output logic        cpu_rst_n,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [15:0] word_cnt,
   output logic [2:0]  dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LEN0  = 3'd1,
      S_LEN1  = 3'd2,
      S_DATA  = 3'd3,
      S_WRITE = 3'd4,
      S_DONE  = 3'd5,
      S_ERROR = 3'd6
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] len_q, len_d;
   logic [1:0]  byte_idx_q, byte_idx_d;
   logic [31:0] word_q, word_d;
   logic [15:0] word_cnt_q, word_cnt_d;
   logic        we_q, we_d;
   logic [31:0] wa_q, wa_d;
   logic [31:0] wd_q, wd_d;
   logic        in_ready_q, in_ready_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic        cpu_rst_n_q, cpu_rst_n_d;

   logic        xfer;
   logic [15:0] new_len;
   logic [31:0] word_nxt;
   logic [15:0] cnt_inc;

   // Handshake: a byte moves on a rising edge when in_valid and in_ready are both high
   // in the cycle before it. in_ready is a registered function of the state only.
   always_comb begin
      xfer     = in_valid & in_ready_q;
      new_len  = {in_data, len_q[7:0]};
      word_nxt = word_q;
      word_nxt[{byte_idx_q, 3'b000} +: 8] = in_data;
      cnt_inc  = word_cnt_q + 16'd1;

      state_d     = state_q;
      len_d       = len_q;
      byte_idx_d  = byte_idx_q;
      word_d      = word_q;
      word_cnt_d  = word_cnt_q;
      we_d        = 1'b0;
      wa_d        = wa_q;
      wd_d        = wd_q;
      busy_d      = busy_q;
      done_d      = done_q;
      err_d       = err_q;
      cpu_rst_n_d = cpu_rst_n_q;

      case (state_q)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start) begin
               state_d     = S_LEN0;
               cpu_rst_n_d = 1'b0;
               busy_d      = 1'b1;
               done_d      = 1'b0;
               err_d       = 1'b0;
               word_cnt_d  = 16'd0;
            end
         end
         S_LEN0: begin
            if (xfer) begin
               len_d[7:0] = in_data;
               state_d    = S_LEN1;
            end
         end
         S_LEN1: begin
            if (xfer) begin
               len_d = new_len;
               if (new_len == 16'd0) begin
                  state_d     = S_DONE;
                  busy_d      = 1'b0;
                  done_d      = 1'b1;
                  cpu_rst_n_d = 1'b1;
               end else if (new_len > 16'(DEPTH)) begin
                  state_d = S_ERROR;
                  busy_d  = 1'b0;
                  err_d   = 1'b1;
               end else begin
                  state_d    = S_DATA;
                  byte_idx_d = 2'd0;
               end
            end
         end
         S_DATA: begin
            if (xfer) begin
               word_d     = word_nxt;
               byte_idx_d = byte_idx_q + 2'd1;
               // The write strobe and address/data are loaded as WRITE is entered.
               if (byte_idx_q == 2'd3) begin
                  state_d = S_WRITE;
                  we_d    = 1'b1;
                  wa_d    = {14'd0, word_cnt_q, 2'b00};
                  wd_d    = word_nxt;
               end
            end
         end
         S_WRITE: begin
            word_cnt_d = cnt_inc;
            if (cnt_inc == len_q) begin
               state_d     = S_DONE;
               busy_d      = 1'b0;
               done_d      = 1'b1;
               cpu_rst_n_d = 1'b1;
            end else begin
               state_d = S_DATA;
            end
         end
         default: state_d = S_IDLE;
      endcase

      in_ready_d = (state_d == S_LEN0) || (state_d == S_LEN1) || (state_d == S_DATA);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         len_q       <= 16'd0;
         byte_idx_q  <= 2'd0;
         word_q      <= 32'd0;
         word_cnt_q  <= 16'd0;
         we_q        <= 1'b0;
         wa_q        <= 32'd0;
         wd_q        <= 32'd0;
         in_ready_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         cpu_rst_n_q <= AUTO_RUN;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         byte_idx_q  <= byte_idx_d;
         word_q      <= word_d;
         word_cnt_q  <= word_cnt_d;
         we_q        <= we_d;
         wa_q        <= wa_d;
         wd_q        <= wd_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         cpu_rst_n_q <= cpu_rst_n_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign WE        = we_q;
   assign WA        = wa_q;
   assign WD        = wd_q;
   assign cpu_rst_n = cpu_rst_n_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign word_cnt  = word_cnt_q;
   assign dbg_state = state_q;

endmodule
